vga_fb_scanout: RTL and testbench

- Scans the 1-bit-per-pixel framebuffer RAM out to a VGA monitor at 640x480@60 Hz.
- Framebuffer is 320x240, stored row-major at addresses 0..76799 of the 17-bit RAM address space. Each stored pixel is shown as a 2x2 block.
- Generates the RAM read address, consumes the registered RAM read data, and drives hsync, vsync, data-enable and 12-bit RGB.
- Sits directly downstream of the framebuffer RAM; clk is the pixel clock (25.175 MHz nominal).

---
 rtl/vga_pkg.sv | 44 ++++
 rtl/vga_fb_scanout_timing.sv | 64 ++++++
 rtl/vga_fb_scanout.sv | 145 ++++++++++++++
 tb/tb_vga_fb_scanout.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pkg
//  Purpose  : 640x480@60 Hz timing constants, framebuffer geometry and the
//             RGB444 pixel type shared by the scanout block and the RAM.
//  Revision : 1.0  initial release
// ============================================================================
package vga_pkg;

    // 640x480@60 Hz horizontal timing (pixel clocks)
    localparam int VGA_H_VIS      = 640;
    localparam int VGA_H_FP       = 16;
    localparam int VGA_H_SYNC     = 96;
    localparam int VGA_H_BP       = 48;
    localparam int VGA_H_TOTAL    = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_HS_START   = VGA_H_VIS + VGA_H_FP;
    localparam int VGA_HS_END     = VGA_HS_START + VGA_H_SYNC - 1;

    // 640x480@60 Hz vertical timing (lines)
    localparam int VGA_V_VIS      = 480;
    localparam int VGA_V_FP       = 10;
    localparam int VGA_V_SYNC     = 2;
    localparam int VGA_V_BP       = 33;
    localparam int VGA_V_TOTAL    = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_VS_START   = VGA_V_VIS + VGA_V_FP;
    localparam int VGA_VS_END     = VGA_VS_START + VGA_V_SYNC - 1;

    // Framebuffer geometry: each stored pixel is shown as a 2x2 block
    localparam int FB_W           = 320;
    localparam int FB_H           = 240;
    localparam int FB_ADDR_W      = 17;
    localparam int FB_DEPTH       = FB_W * FB_H;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    localparam logic [11:0] RGB_WHITE = 12'hFFF;
    localparam logic [11:0] RGB_BLACK = 12'h000;

endpackage
`default_nettype wire

// File: rtl/vga_fb_scanout_timing.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing
//  Purpose  : Free-running h/v raster counters plus the raw (undelayed)
//             hsync/vsync/visible/first-pixel flags for the current position.
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing #(
    parameter int H_VIS  = vga_pkg::VGA_H_VIS,
    parameter int H_FP   = vga_pkg::VGA_H_FP,
    parameter int H_SYNC = vga_pkg::VGA_H_SYNC,
    parameter int H_BP   = vga_pkg::VGA_H_BP,
    parameter int V_VIS  = vga_pkg::VGA_V_VIS,
    parameter int V_FP   = vga_pkg::VGA_V_FP,
    parameter int V_SYNC = vga_pkg::VGA_V_SYNC,
    parameter int V_BP   = vga_pkg::VGA_V_BP,
    parameter int H_CNT_W = $clog2(H_VIS + H_FP + H_SYNC + H_BP),
    parameter int V_CNT_W = $clog2(V_VIS + V_FP + V_SYNC + V_BP)
) (
    input  logic               clk,
    input  logic               rst,
    output logic [H_CNT_W-1:0] h_cnt,
    output logic [V_CNT_W-1:0] v_cnt,
    output logic               h_wrap,
    output logic               frame_wrap,
    output logic               visible,
    output logic               hsync_n,
    output logic               vsync_n,
    output logic               first_pixel
);

    localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VIS + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_VIS + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    logic v_last;

    assign h_wrap     = (h_cnt == H_CNT_W'(H_TOTAL - 1));
    assign v_last     = (v_cnt == V_CNT_W'(V_TOTAL - 1));
    assign frame_wrap = h_wrap && v_last;

    // Raster position: h advances every clock, v advances on each h wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign visible     = (h_cnt < H_CNT_W'(H_VIS)) && (v_cnt < V_CNT_W'(V_VIS));
    assign hsync_n     = !((h_cnt >= H_CNT_W'(HS_START)) && (h_cnt <= H_CNT_W'(HS_END)));
    assign vsync_n     = !((v_cnt >= V_CNT_W'(VS_START)) && (v_cnt <= V_CNT_W'(VS_END)));
    assign first_pixel = (h_cnt == '0) && (v_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/vga_fb_scanout.sv
`default_nettype none
// ============================================================================
//  Module   : vga_fb_scanout
//  Purpose  : Scans a 1-bpp 320x240 framebuffer out as 640x480@60 Hz VGA,
//             pixel-doubled in both directions. Issues registered RAM read
//             addresses and aligns sync/de/frame_start with the returned data.
//  Revision : 1.0  initial release
// ============================================================================
module vga_fb_scanout #(
    parameter int          H_VIS  = vga_pkg::VGA_H_VIS,
    parameter int          H_FP   = vga_pkg::VGA_H_FP,
    parameter int          H_SYNC = vga_pkg::VGA_H_SYNC,
    parameter int          H_BP   = vga_pkg::VGA_H_BP,
    parameter int          V_VIS  = vga_pkg::VGA_V_VIS,
    parameter int          V_FP   = vga_pkg::VGA_V_FP,
    parameter int          V_SYNC = vga_pkg::VGA_V_SYNC,
    parameter int          V_BP   = vga_pkg::VGA_V_BP,
    parameter int          FB_W   = vga_pkg::FB_W,
    parameter int          ADDR_W = vga_pkg::FB_ADDR_W,
    parameter logic [11:0] FG     = vga_pkg::RGB_WHITE,
    parameter logic [11:0] BG     = vga_pkg::RGB_BLACK
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [7:0]        mem_data,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [11:0]       rgb,
    output logic              frame_start
);

    import vga_pkg::*;

    localparam int H_CNT_W = $clog2(H_VIS + H_FP + H_SYNC + H_BP);
    localparam int V_CNT_W = $clog2(V_VIS + V_FP + V_SYNC + V_BP);

    logic [H_CNT_W-1:0] h_cnt;
    logic [V_CNT_W-1:0] v_cnt;
    logic               h_wrap;
    logic               frame_wrap;
    logic               visible;
    logic               hsync_n;
    logic               vsync_n;
    logic               first_pixel;

    logic [ADDR_W-1:0]  row_base;
    logic               odd_visible_line;

    // Two intermediate stages for the raster flags; the third stage is the
    // output register, which lines them up with rgb built from mem_data.
    logic [1:0]         de_pipe;
    logic [1:0]         hs_pipe;
    logic [1:0]         vs_pipe;
    logic [1:0]         fs_pipe;
    rgb444_t            pixel;

    // Only bit 0 of the RAM word carries pixel data
    logic               unused_mem_bits;
    assign unused_mem_bits = ^mem_data[7:1];

    vga_timing #(
        .H_VIS   (H_VIS),
        .H_FP    (H_FP),
        .H_SYNC  (H_SYNC),
        .H_BP    (H_BP),
        .V_VIS   (V_VIS),
        .V_FP    (V_FP),
        .V_SYNC  (V_SYNC),
        .V_BP    (V_BP),
        .H_CNT_W (H_CNT_W),
        .V_CNT_W (V_CNT_W)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .h_wrap      (h_wrap),
        .frame_wrap  (frame_wrap),
        .visible     (visible),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .first_pixel (first_pixel)
    );

    // Display lines 2k and 2k+1 share framebuffer row k, so the row base only
    // steps after the odd line of each visible pair.
    assign odd_visible_line = v_cnt[0] && (v_cnt < V_CNT_W'(V_VIS));

    // Row base accumulator replaces a (v/2)*FB_W multiplier
    always_ff @(posedge clk) begin
        if (rst) begin
            row_base <= '0;
        end else if (frame_wrap) begin
            row_base <= '0;
        end else if (h_wrap && odd_visible_line) begin
            row_base <= row_base + ADDR_W'(FB_W);
        end
    end

    // Read address for the current raster position; parked at 0 in blanking
    always_ff @(posedge clk) begin
        if (rst) begin
            read_addr <= '0;
        end else if (visible) begin
            read_addr <= row_base + ADDR_W'(h_cnt >> 1);
        end else begin
            read_addr <= '0;
        end
    end

    // Latency-matching delay line and colour mux; blanking is forced black
    always_ff @(posedge clk) begin
        if (rst) begin
            de_pipe     <= '0;
            hs_pipe     <= '1;
            vs_pipe     <= '1;
            fs_pipe     <= '0;
            de          <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
            pixel       <= '0;
        end else begin
            de_pipe     <= {de_pipe[0], visible};
            hs_pipe     <= {hs_pipe[0], hsync_n};
            vs_pipe     <= {vs_pipe[0], vsync_n};
            fs_pipe     <= {fs_pipe[0], first_pixel};
            de          <= de_pipe[1];
            hsync       <= hs_pipe[1];
            vsync       <= vs_pipe[1];
            frame_start <= fs_pipe[1];
            if (de_pipe[1]) begin
                pixel <= mem_data[0] ? rgb444_t'(FG) : rgb444_t'(BG);
            end else begin
                pixel <= '0;
            end
        end
    end

    assign rgb = pixel;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_scanout.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_vga_fb_scanout
//  Purpose  : Scoreboard bench for vga_fb_scanout on a reduced raster
//             (56x37 total, 40x30 visible, 20-pixel framebuffer rows).
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_fb_scanout;

    localparam int H_VIS  = 40;
    localparam int H_FP   = 4;
    localparam int H_SYNC = 8;
    localparam int H_BP   = 4;
    localparam int V_VIS  = 30;
    localparam int V_FP   = 2;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 3;
    localparam int FB_W   = 20;
    localparam int ADDR_W = 17;
    localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME  = H_TOT * V_TOT;
    localparam int MAX_ADDR = (V_VIS / 2) * FB_W - 1;
    localparam logic [11:0] FG = 12'hFFF;
    localparam logic [11:0] BG = 12'h000;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [11:0] rgb;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] read_addr;
    logic [7:0]        mem_data = 8'h00;
    logic              hsync;
    logic              vsync;
    logic              de;
    logic [11:0]       rgb;
    logic              frame_start;

    vga_fb_scanout #(
        .H_VIS (H_VIS), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_VIS (V_VIS), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .FB_W (FB_W), .ADDR_W (ADDR_W), .FG (FG), .BG (BG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .read_addr   (read_addr),
        .mem_data    (mem_data),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .rgb         (rgb),
        .frame_start (frame_start)
    );

    always #20 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // RAM model: mode 0 = checkerboard of stored pixels, mode 1 = only addr 5 set
    int ram_mode = 0;

    function automatic logic ram_bit(input int a);
        if (ram_mode == 0) return logic'((a % 2) ^ ((a / FB_W) % 2));
        return (a == 5);
    endfunction

    // 1-cycle registered read
    always @(posedge clk) mem_data <= {read_addr[6:0], ram_bit(int'(read_addr))};

    // Reference raster position
    int mh = 0;
    int mv = 0;
    always @(posedge clk) begin
        if (rst) begin
            mh <= 0;
            mv <= 0;
        end else if (mh == H_TOT - 1) begin
            mh <= 0;
            mv <= (mv == V_TOT - 1) ? 0 : mv + 1;
        end else begin
            mh <= mh + 1;
        end
    end

    function automatic int model_addr(input int h, input int v);
        if (h < H_VIS && v < V_VIS) return (v / 2) * FB_W + h / 2;
        return 0;
    endfunction

    function automatic exp_t model_out(input int h, input int v);
        exp_t e;
        logic vis;
        vis   = (h < H_VIS) && (v < V_VIS);
        e.hs  = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
        e.vs  = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
        e.de  = vis;
        e.fs  = (h == 0) && (v == 0);
        e.rgb = vis ? (ram_bit(model_addr(h, v)) ? FG : BG) : 12'h000;
        return e;
    endfunction

    localparam exp_t RESET_EXP = '{hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0, rgb: 12'h000};

    exp_t sbq[$];
    int   exp_addr, ph, pv, cyc, last_fs, fs_seen, vs_low, fg_cnt, hs_w, max_addr;
    logic hs_prev, hfall_done;

    task automatic push_model();
        sbq.push_back(model_out(mh, mv));
        exp_addr = model_addr(mh, mv);
        ph = mh;
        pv = mv;
    endtask

    task automatic check_reset_outputs(input string tag);
        exp_t got;
        got = '{hs: hsync, vs: vsync, de: de, fs: frame_start, rgb: rgb};
        check(tag, got, RESET_EXP);
        check({tag, "_addr"}, read_addr, 0);
    endtask

    // Check reset state one more cycle, then release and prime the scoreboard
    task automatic release_reset();
        @(negedge clk);
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        sbq.delete();
        sbq.push_back(RESET_EXP);
        sbq.push_back(RESET_EXP);
        cyc = 0; last_fs = -1; fs_seen = 0; vs_low = 0; fg_cnt = 0;
        hs_w = 0; hs_prev = 1'b1; hfall_done = 1'b0; max_addr = 0;
        push_model();
    endtask

    // One cycle after release: compare outputs against the scoreboard and
    // the timing landmarks, then queue the expectation for this position.
    task automatic sb_step();
        exp_t e;
        exp_t got;
        @(negedge clk);
        cyc++;
        got = '{hs: hsync, vs: vsync, de: de, fs: frame_start, rgb: rgb};
        if (sbq.size() == 0) begin
            check("sb_underflow", 1, 0);
        end else begin
            e = sbq.pop_front();
            check("out", got, e);
        end
        check("read_addr", read_addr, exp_addr);
        if (ph == 0 && pv == 2)                 check("addr_l2_h0", read_addr, FB_W);
        if (ph == H_VIS - 1 && pv == V_VIS - 1) check("addr_last", read_addr, MAX_ADDR);
        if (int'(read_addr) > max_addr) max_addr = int'(read_addr);

        if (frame_start) begin
            fs_seen++;
            if (last_fs < 0) begin
                check("fs_first", cyc, 3);
            end else begin
                check("fs_period", cyc - last_fs, FRAME);
                check("vs_low", vs_low, V_SYNC * H_TOT);
                if (ram_mode == 1) check("fg_pixels", fg_cnt, 4);
            end
            last_fs = cyc;
            vs_low  = 0;
            fg_cnt  = 0;
        end
        if (!vsync) vs_low++;
        if (de && rgb == FG) fg_cnt++;

        if (!hs_prev && hsync && hfall_done) check("hs_width", hs_w, H_SYNC);
        if (hs_prev && !hsync) begin
            if (!hfall_done) check("hs_fall", cyc, H_VIS + H_FP + 3);
            hfall_done = 1'b1;
            hs_w = 0;
        end
        if (!hsync) hs_w++;
        hs_prev = hsync;

        push_model();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        ram_mode = 0;
        repeat (5) begin
            @(negedge clk);
            check_reset_outputs("rst");
        end

        // Phase A: checkerboard framebuffer, two full frames
        release_reset();
        repeat (2 * FRAME + 100) sb_step();
        check("fs_count_a", fs_seen, 3);
        check("max_addr", max_addr, MAX_ADDR);

        // Phase B: one-cycle reset at mid-frame, then latency pattern
        n = 0;
        while (!(mh == 30 && mv == 20) && n < FRAME + 10) begin
            sb_step();
            n++;
        end
        check("reach_mid", (mh == 30 && mv == 20), 1);
        rst = 1'b1;
        ram_mode = 1;
        release_reset();
        repeat (2 * FRAME + 100) sb_step();
        check("fs_count_b", fs_seen, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
